// File: rtl/regfile_pkg.sv
// regfile_pkg: state type and packed-port slice helper shared by the register file.
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} regfile_state_t;
  function automatic int port_lo(int port, int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-entry pending-write bits with set, clear, flush and NUM_RD lookups.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int NUM_RD = 3,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     set_en_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  input  logic                     clr_en_i,
  input  logic [ADDR_W-1:0]        clr_addr_i,
  input  logic                     flush_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        pend_o
);
  logic [DEPTH-1:0] pend_q, pend_d;
  // set is applied after clear so a same-cycle issue to the written entry stays pending
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
    if (flush_i) pend_d = '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pend_q <= '0;
    else pend_q <= pend_d;
  for (genvar g = 0; g < NUM_RD; g++) begin : g_look
    assign pend_o[g] = pend_q[rd_addr_i[port_lo(g, ADDR_W) +: ADDR_W]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, pending-write scoreboard
// and a sequential clear engine that zeroes one entry per cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int NUM_RD = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_addr,
  input  logic                     clear_req,
  output logic                     clear_busy
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  regfile_state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NUM_RD-1:0] pend;
  logic idle, wr_ok, lock_ok;
  assign idle = state_q == IDLE;
  // a clear request in the same cycle wins over the write
  assign wr_ok = idle && wr_en && !clear_req && !(ZERO_REG && wr_addr == '0);
  assign lock_ok = idle && lock_en && !(ZERO_REG && lock_addr == '0);
  assign clear_busy = reset_n && !idle;
  always_comb begin
    state_d = idle ? (clear_req ? CLEAR : IDLE) : (cnt_q == LAST ? IDLE : CLEAR);
    cnt_d = idle ? '0 : cnt_q + ADDR_W'(1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    else if (!idle) mem_q[cnt_q] <= '0;
    else if (wr_ok) mem_q[wr_addr] <= wr_data;
  regfile_scoreboard #(.DEPTH(DEPTH), .NUM_RD(NUM_RD)) u_sb (
    .clk(clk),
    .reset_n(reset_n),
    .set_en_i(lock_ok),
    .set_addr_i(lock_addr),
    .clr_en_i(wr_ok),
    .clr_addr_i(wr_addr),
    .flush_i(idle && clear_req),
    .rd_addr_i(rd_addr),
    .pend_o(pend)
  );
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic hit;
    assign ra = rd_addr[port_lo(g, ADDR_W) +: ADDR_W];
    assign hit = BYPASS && wr_en && wr_addr == ra;
    assign rd_data[port_lo(g, DATA_W) +: DATA_W] =
      (!reset_n || !idle || (ZERO_REG && ra == '0)) ? '0 : hit ? wr_data : mem_q[ra];
    assign rd_pend[g] = reset_n && idle && pend[g];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus against a behavioural model for the default and no-bypass
// builds, plus literal checks on a 16-entry four-port build.
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic [14:0] ra;
  logic wr_en, lock_en, clear_req;
  logic [4:0] wa, la;
  logic [31:0] wd;
  logic [95:0] rdat0, rdat1;
  logic [2:0] rp0, rp1;
  logic busy0, busy1;
  logic [15:0] ra2;
  logic we2, cr2, busy2;
  logic lk2 = 1'b0;
  logic [3:0] wa2, la2;
  logic [31:0] wd2;
  logic [127:0] rdat2;
  logic [3:0] rp2;
  int checks = 0, failures = 0, n;

  regfile_mp u0 (.clk(clk), .reset_n(reset_n), .rd_addr(ra), .rd_data(rdat0), .rd_pend(rp0),
    .wr_en(wr_en), .wr_addr(wa), .wr_data(wd), .lock_en(lock_en), .lock_addr(la),
    .clear_req(clear_req), .clear_busy(busy0));
  regfile_mp #(.BYPASS(1'b0)) u1 (.clk(clk), .reset_n(reset_n), .rd_addr(ra), .rd_data(rdat1),
    .rd_pend(rp1), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd), .lock_en(lock_en), .lock_addr(la),
    .clear_req(clear_req), .clear_busy(busy1));
  regfile_mp #(.DEPTH(16), .NUM_RD(4)) u2 (.clk(clk), .reset_n(reset_n), .rd_addr(ra2),
    .rd_data(rdat2), .rd_pend(rp2), .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .lock_en(lk2),
    .lock_addr(la2), .clear_req(cr2), .clear_busy(busy2));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // model: entry contents, pending flags, and remaining clear cycles
  bit [31:0] mm [32];
  bit mp [32];
  int left;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < 32; k++) begin
        mm[k] <= '0;
        mp[k] <= 1'b0;
      end
      left <= 0;
    end else if (left != 0) begin
      mm[32 - left] <= '0;
      left <= left - 1;
    end else if (clear_req) begin
      for (int k = 0; k < 32; k++) mp[k] <= 1'b0;
      left <= 32;
    end else begin
      if (wr_en && wa != 5'd0) begin
        mm[wa] <= wd;
        mp[wa] <= 1'b0;
      end
      if (lock_en && la != 5'd0) mp[la] <= 1'b1;
    end

  logic [95:0] e_b, e_n;
  logic [2:0] e_p;
  always_comb begin
    e_b = '0;
    e_n = '0;
    e_p = '0;
    for (int i = 0; i < 3; i++)
      if (reset_n && left == 0 && ra[i*5 +: 5] != 5'd0) begin
        e_n[i*32 +: 32] = mm[ra[i*5 +: 5]];
        e_b[i*32 +: 32] = (wr_en && wa == ra[i*5 +: 5]) ? wd : mm[ra[i*5 +: 5]];
        e_p[i] = mp[ra[i*5 +: 5]];
      end
  end
  always @(negedge clk) begin
    chk("cyc_rd_bypass", 128'(rdat0), 128'(e_b));
    chk("cyc_rd_nobypass", 128'(rdat1), 128'(e_n));
    chk("cyc_pend", 128'({rp1, rp0}), 128'({e_p, e_p}));
    chk("cyc_busy", 128'({busy1, busy0}), 128'({2{left != 0}}));
  end

  int adr [4] = '{3, 6, 9, 15};
  initial begin
    reset_n = 1'b0; ra = {5'd0, 5'd0, 5'd5}; wr_en = 1'b1; wa = 5'd5; wd = 32'hFF;
    lock_en = 1'b0; la = 5'd0; clear_req = 1'b0;
    ra2 = '0; we2 = 1'b0; wa2 = '0; la2 = '0; wd2 = '0; cr2 = 1'b0;
    @(negedge clk);
    chk("reset_rd", 128'(rdat0), 128'(0));
    chk("reset_busy", 128'(busy0), 128'(0));
    nxt();
    wr_en = 1'b0;
    reset_n = 1'b1;
    nxt();
    wr_en = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; nxt();
    wr_en = 1'b0;
    @(negedge clk); chk("wr5", 128'(rdat0[31:0]), 128'(32'hDEADBEEF)); nxt();
    wr_en = 1'b1; wa = 5'd0; wd = 32'h1234; ra[4:0] = 5'd0; nxt();
    wr_en = 1'b0;
    @(negedge clk); chk("zero_reg", 128'(rdat0[31:0]), 128'(0)); nxt();
    ra[9:5] = 5'd7; wr_en = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
    @(negedge clk);
    chk("byp_on", 128'(rdat0[63:32]), 128'(32'hA5A5A5A5));
    chk("byp_off_old", 128'(rdat1[63:32]), 128'(0));
    nxt();
    wr_en = 1'b0;
    @(negedge clk); chk("byp_off_new", 128'(rdat1[63:32]), 128'(32'hA5A5A5A5)); nxt();
    ra[14:10] = 5'd9; lock_en = 1'b1; la = 5'd9; nxt();
    lock_en = 1'b0;
    @(negedge clk); chk("lock9", 128'(rp0[2]), 128'(1)); nxt();
    wr_en = 1'b1; wa = 5'd9; wd = 32'h99;
    @(negedge clk); chk("pend_not_bypassed", 128'(rp0[2]), 128'(1)); nxt();
    wr_en = 1'b0;
    @(negedge clk); chk("wr9_unlock", 128'(rp0[2]), 128'(0)); nxt();
    lock_en = 1'b1; wr_en = 1'b1; nxt();
    lock_en = 1'b0; wr_en = 1'b0;
    @(negedge clk); chk("lock_wins", 128'(rp0[2]), 128'(1)); nxt();
    la = 5'd0; ra[14:10] = 5'd0; lock_en = 1'b1; nxt();
    lock_en = 1'b0;
    @(negedge clk); chk("lock0", 128'(rp0[2]), 128'(0)); nxt();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wa = 5'(i); wd = 32'(i + 1); nxt();
    end
    wr_en = 1'b0; lock_en = 1'b1; la = 5'd4; nxt();
    lock_en = 1'b0; ra = {5'd4, 5'd17, 5'd31};
    @(negedge clk);
    chk("fill_rd", 128'(rdat0), 128'({32'd5, 32'd18, 32'd32}));
    chk("fill_pend", 128'(rp0), 128'(3'b100));
    nxt();
    clear_req = 1'b1; wr_en = 1'b1; wa = 5'd3; wd = 32'hFFFF; nxt();
    clear_req = 1'b0; wr_en = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      wr_en = (c == 20); lock_en = (c == 20); wa = 5'd2; la = 5'd2; wd = 32'h77;
      @(negedge clk);
      if (busy0) n++;
      nxt();
    end
    wr_en = 1'b0; lock_en = 1'b0;
    chk("clear_len", 128'(n), 128'(32));
    for (int i = 0; i < 32; i++) begin
      ra = {5'(i), 5'(i), 5'(i)};
      @(negedge clk);
      chk("cleared_rd", 128'(rdat0), 128'(0));
      chk("cleared_pend", 128'(rp0), 128'(0));
      nxt();
    end
    wr_en = 1'b1; wa = 5'd20; wd = 32'hCD; nxt();
    wr_en = 1'b0; clear_req = 1'b1; nxt();
    clear_req = 1'b0;
    repeat (10) nxt();
    ra = {5'd0, 5'd0, 5'd20};
    @(negedge clk); chk("mid_clear_busy", 128'(busy0), 128'(1)); nxt();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", 128'(busy0), 128'(0));
    chk("rst_rd", 128'(rdat0[31:0]), 128'(0));
    nxt();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 128'(busy0), 128'(0));
    chk("post_rst_rd20", 128'(rdat0[31:0]), 128'(0));
    nxt();
    wr_en = 1'b1; wa = 5'd3; wd = 32'h55; ra[4:0] = 5'd3; nxt();
    wr_en = 1'b0;
    @(negedge clk); chk("post_rst_wr", 128'(rdat1[31:0]), 128'(32'h55)); nxt();
    for (int i = 0; i < 4; i++) begin
      we2 = 1'b1; wa2 = 4'(adr[i]); wd2 = 32'(adr[i] * 17); nxt();
    end
    we2 = 1'b0; ra2 = {4'd15, 4'd9, 4'd6, 4'd3};
    @(negedge clk); chk("d16_rd4", rdat2, {32'hFF, 32'h99, 32'h66, 32'h33}); nxt();
    ra2 = {4'd3, 4'd0, 4'd15, 4'd6};
    @(negedge clk);
    chk("d16_perm", rdat2, {32'h33, 32'h0, 32'hFF, 32'h66});
    chk("d16_pend", 128'(rp2), 128'(0));
    nxt();
    cr2 = 1'b1; nxt();
    cr2 = 1'b0;
    n = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (busy2) n++;
      nxt();
    end
    chk("d16_clear_len", 128'(n), 128'(16));
    @(negedge clk); chk("d16_after_clear", rdat2, 128'(0)); nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
